// File: rtl/ldpc_dec_mem_ctrl_if.sv
// Memory-side streams of the LDPC layer sequencer: linear read stream into the
// shift-RAM array and the delayed write stream for node engine results.
interface ldpc_dec_mem_ctrl_if #(
  parameter int pADDR_W = 8,
  parameter int pTAG_W  = 2
);
  // Strobe semantics, no backpressure: a beat transfers on every enabled clock
  // where the strobe is high; address and tag are only meaningful with it and
  // read as zero otherwise. The memory cannot stall the sequencer.
  logic              orread;
  logic [pADDR_W-1:0] oraddr;
  logic [pTAG_W-1:0]  ortag;
  logic              owrite;
  logic [pADDR_W-1:0] owaddr;
  logic [pTAG_W-1:0]  owtag;

  modport master (output orread, oraddr, ortag, owrite, owaddr, owtag);
  modport slave  (input  orread, oraddr, ortag, owrite, owaddr, owtag);
endinterface

// File: rtl/ldpc_dec_mem_ctrl.sv
// Layer/iteration sequencer for the LDPC shift-RAM array: read stream per layer,
// matching write stream D cycles later, and a layer barrier until writes retire.
module ldpc_dec_mem_ctrl #(
  parameter int pROW_NUM  = 8,
  parameter int pCOL_NUM  = 16,
  parameter int pADDR_W   = 8,
  parameter int pITER_W   = 5,
  parameter int pMEM_RLAT = 4,
  parameter int pPROC_LAT = 6,
  parameter int pTAG_W    = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pITER_W-1:0] initer,
  input  logic               iearly_stop,
  ldpc_dec_mem_ctrl_if.master mem,
  output logic [pITER_W-1:0] oiter,
  output logic               obusy,
  output logic               odone,
  output logic [1:0]         ostate
);
  localparam int D  = pMEM_RLAT + pPROC_LAT;
  localparam int LW = (pROW_NUM > 1) ? $clog2(pROW_NUM) : 1;
  localparam int CW = $clog2(pCOL_NUM);
  localparam int DW = $clog2(D + 1);
  localparam int PW = 1 + pADDR_W + pTAG_W;

  if (pROW_NUM < 1 || pCOL_NUM < 2 || pTAG_W < 2 || D < 1 ||
      pROW_NUM * pCOL_NUM > 2 ** pADDR_W) begin : g_param_check
    $error("ldpc_dec_mem_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      col;
  logic [LW-1:0]      layer;
  logic [pITER_W-1:0] iter, niter;
  logic [pADDR_W-1:0] raddr;
  logic [DW-1:0]      dcnt;
  logic [PW-1:0]      pipe [D];

  logic               col_last, layer_last, drain_end, iter_end;
  logic               rd, busy, done;
  logic [pTAG_W-1:0]  tag;

  assign col_last   = (col == CW'(pCOL_NUM - 1));
  assign layer_last = (layer == LW'(pROW_NUM - 1));
  assign drain_end  = (dcnt == DW'(D));
  // Early stop only matters on the last layer's decision cycle.
  assign iter_end   = iearly_stop ||
                      ((pITER_W+1)'(iter) + (pITER_W+1)'(1) == (pITER_W+1)'(niter));

  always_ff @(posedge iclk) begin
    if (!ireset)      state <= S_IDLE;
    else if (iclkena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (istart) state_nxt = S_READ;
      S_READ: begin
        rd   = 1'b1;
        busy = 1'b1;
        if (col_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_end) state_nxt = (layer_last && iter_end) ? S_DONE : S_READ;
      end
      S_DONE:  begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tag = '0;
    if (rd) begin
      tag[0] = (col == '0);
      tag[1] = col_last;
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      col   <= '0;
      layer <= '0;
      iter  <= '0;
      niter <= '0;
      raddr <= '0;
      dcnt  <= '0;
      for (int i = 0; i < D; i++) pipe[i] <= '0;
    end else if (iclkena) begin
      case (state)
        S_IDLE: if (istart) begin
          niter <= (initer == '0) ? pITER_W'(1) : initer;
          col   <= '0;
          layer <= '0;
          iter  <= '0;
          raddr <= '0;
        end
        S_READ: begin
          col   <= col_last ? '0 : col + CW'(1);
          raddr <= raddr + pADDR_W'(1);
          dcnt  <= '0;
        end
        S_DRAIN: begin
          // The read address runs linearly across layers; it only rewinds per iteration.
          if (!drain_end) dcnt <= dcnt + DW'(1);
          else if (!layer_last) layer <= layer + LW'(1);
          else begin
            layer <= '0;
            raddr <= '0;
            if (!iter_end) iter <= iter + pITER_W'(1);
          end
        end
        default: ;
      endcase
      pipe[0] <= {rd, (rd ? raddr : '0), tag};
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem.orread = rd;
  assign mem.oraddr = rd ? raddr : '0;
  assign mem.ortag  = tag;
  assign {mem.owrite, mem.owaddr, mem.owtag} = pipe[D-1];
  assign oiter  = iter;
  assign obusy  = busy;
  assign odone  = done;
  assign ostate = state;
endmodule

// File: tb/tb_ldpc_dec_mem_ctrl.sv
// Bench for ldpc_dec_mem_ctrl: per-cycle comparison against a schedule model
// derived from layer period arithmetic, plus a write-address expected queue.
module tb_ldpc_dec_mem_ctrl;
  localparam int R  = 2;
  localparam int C  = 4;
  localparam int RL = 4;
  localparam int PL = 6;
  localparam int D  = RL + PL;
  localparam int P  = C + D + 1;
  localparam int AW = 8;
  localparam int IW = 5;
  localparam int TW = 2;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
  } beat_t;

  logic          iclk = 1'b0;
  logic          ireset, iclkena, istart, iearly_stop;
  logic [IW-1:0] initer, oiter;
  logic          obusy, odone;
  logic [1:0]    ostate;

  int            checks = 0;
  int            failures = 0;
  logic [AW-1:0] exp_q[$];
  int            last_iter = 0;

  ldpc_dec_mem_ctrl_if #(.pADDR_W(AW), .pTAG_W(TW)) mem ();

  ldpc_dec_mem_ctrl #(
    .pROW_NUM(R), .pCOL_NUM(C), .pADDR_W(AW), .pITER_W(IW),
    .pMEM_RLAT(RL), .pPROC_LAT(PL), .pTAG_W(TW)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .initer(initer), .iearly_stop(iearly_stop), .mem(mem),
    .oiter(oiter), .obusy(obusy), .odone(odone), .ostate(ostate)
  );

  // clock / reset block
  always #5 iclk = ~iclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference schedule: each layer occupies P cycles, reads in its first C.
  function automatic beat_t read_at(input int n, input int layers);
    beat_t b;
    int s, pos;
    b = '0;
    if (n >= 0) begin
      s   = n / P;
      pos = n % P;
      if (s < layers && pos < C) begin
        b.v = 1'b1;
        b.a = AW'((s % R) * C + pos);
        b.t = TW'({pos == C - 1, pos == 0});
      end
    end
    return b;
  endfunction

  // driver: one decode; stop_it<0 = no early stop, abort_n<0 = no reset
  task automatic run(input int nit, input int stop_it, input int gap_mode, input int abort_n);
    int iters, layers, n, guard, gap_left;
    bit gap_done, fresh, abort;
    beat_t rb, wb;
    iters = (nit == 0) ? 1 : nit;
    if (stop_it >= 0 && stop_it < iters) iters = stop_it + 1;
    layers = iters * R;

    @(negedge iclk);
    chk("idle_busy", 32'(obusy), 32'(0));
    chk("idle_iter", 32'(oiter), 32'(last_iter));
    istart = 1'b1; initer = IW'(nit); iclkena = 1'b1; iearly_stop = 1'b0;
    @(posedge iclk);
    n = 0; guard = 0; gap_left = 0; gap_done = 0; fresh = 1; abort = 0;

    while (n <= layers * P + 1 && guard < 4000) begin
      @(negedge iclk);
      guard++;
      rb = read_at(n, layers);
      wb = read_at(n - D, layers);
      chk("read", 32'({mem.orread, mem.oraddr, mem.ortag}), 32'(rb));
      chk("write", 32'({mem.owrite, mem.owaddr, mem.owtag}), 32'(wb));
      chk("busy", 32'(obusy), 32'(n < layers * P));
      chk("done", 32'(odone), 32'(n == layers * P));
      chk("iter", 32'(oiter), 32'((n < layers * P) ? (n / P) / R : iters - 1));
      if (fresh) begin
        if (rb.v) exp_q.push_back(rb.a);
        if (mem.owrite) begin
          chk("wq_nonempty", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) chk("wq_addr", 32'(mem.owaddr), 32'(exp_q.pop_front()));
        end
      end

      istart = (n <= layers * P) && (n == layers * P || $urandom_range(0, 3) == 0);
      iearly_stop = (stop_it >= 0 && n == layers * P - 1) ? 1'b1 :
                    ((n % P != P - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (gap_mode == 2 && n == 1 && !gap_done) begin
        gap_left = 3;
        gap_done = 1;
      end
      if (gap_left > 0) begin
        iclkena = 1'b0;
        gap_left--;
      end else if (gap_mode == 1) iclkena = ($urandom_range(0, 5) != 0);
      else iclkena = 1'b1;
      if (n == abort_n) begin
        ireset = 1'b0; iclkena = 1'b1; istart = 1'b0; abort = 1;
      end
      @(posedge iclk);
      if (abort) break;
      fresh = iclkena;
      if (iclkena) n++;
    end
    chk("bound", 32'(guard < 4000), 32'(1));

    if (abort) begin
      @(negedge iclk);
      ireset = 1'b1; iearly_stop = 1'b0;
      chk("rst_bus", 32'({mem.orread, mem.oraddr, mem.ortag, mem.owrite, mem.owaddr, mem.owtag}), 32'(0));
      chk("rst_stat", 32'({obusy, odone, oiter}), 32'(0));
      for (int i = 0; i < 2 * D; i++) begin
        @(negedge iclk);
        chk("abort_quiet", 32'({odone, mem.owrite, obusy}), 32'(0));
      end
      exp_q.delete();
      last_iter = 0;
    end else begin
      chk("wq_drained", 32'(exp_q.size()), 32'(0));
      last_iter = iters - 1;
    end
    istart = 1'b0;
  endtask

  initial begin
    ireset = 1'b0; iclkena = 1'b1; istart = 1'b0; iearly_stop = 1'b0; initer = '0;
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    chk("reset_bus", 32'({mem.orread, mem.oraddr, mem.ortag, mem.owrite, mem.owaddr, mem.owtag}), 32'(0));
    chk("reset_stat", 32'({obusy, odone, oiter}), 32'(0));
    ireset = 1'b1;

    run(1, -1, 0, -1);      // two layers, single iteration
    run(3, -1, 0, -1);      // six layers, oiter 0,1,2
    run(5, 0, 0, -1);       // early stop at end of iteration 0
    run(2, -1, 2, -1);      // three-cycle clock-enable gap mid-READ
    run(3, -1, 0, C + 3);   // reset inside the first DRAIN
    run(0, -1, 0, -1);      // initer=0 behaves as one iteration
    for (int k = 0; k < 4; k++)
      run($urandom_range(0, 4), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ldpc_dec_mem_ctrl.md
Name: ldpc_dec_mem_ctrl

Overview:
- Layer/iteration sequencer for the LDPC decoder shift-RAM array. Issues the linear read stream (address, tag, strobe) into the memory and generates the matching write stream for the node engine results, delayed by the fixed read+process latency.
- Enforces the layered-decoding hazard: the next layer reads only after every write of the current layer has retired. Counts iterations and honours early stop.

Parameters:
- pROW_NUM, 8, layers per iteration (>=1)
- pCOL_NUM, 16, read cycles per layer (>=2)
- pADDR_W, 8, memory address width; requires pROW_NUM*pCOL_NUM <= 2**pADDR_W
- pITER_W, 5, iteration counter width
- pMEM_RLAT, 4, memory read latency, iraddr to ordat
- pPROC_LAT, 6, node engine latency, ordat to write data valid
- pTAG_W, 2, tag width (>=2)

Ports:
- iclk, in, 1, clock
- ireset, in, 1, reset, synchronous, active-low
- iclkena, in, 1, clock enable; when 0 all state freezes
- istart, in, 1, start decode, accepted in IDLE only
- initer, in, pITER_W, maximum iterations (0 treated as 1), sampled on accepted istart
- iearly_stop, in, 1, syndrome-OK flag from check unit
- orread, out, 1, read strobe
- oraddr, out, pADDR_W, read address
- ortag, out, pTAG_W, bit0 = first column of layer, bit1 = last column of layer, upper bits 0
- owrite, out, 1, write strobe
- owaddr, out, pADDR_W, write address
- owtag, out, pTAG_W, delayed copy of ortag
- oiter, out, pITER_W, current iteration index
- obusy, out, 1, high from accepted istart until odone
- odone, out, 1, one-cycle pulse at end of decode

Behaviour:
- Reset (ireset=0 at a clock edge): FSM to IDLE; all outputs 0; delay pipeline cleared. Reset mid-decode aborts with no odone.
- All updates gated by iclkena. A pipeline stage advances only on cycles with iclkena=1.
- Let D = pMEM_RLAT + pPROC_LAT.
- FSM states:
  - IDLE: istart=1 -> latch max(initer,1) into niter; zero layer, col, iter; go READ; obusy=1 from next cycle.
  - READ: orread=1, oraddr = layer*pCOL_NUM + col. ortag[0] = (col==0), ortag[1] = (col==pCOL_NUM-1). col increments each cycle. At col==pCOL_NUM-1, go DRAIN.
  - DRAIN: orread=0. Stay until the write pipe is empty, i.e. the last write of the layer has issued; this costs D cycles after the last read. Then:
    - if layer < pROW_NUM-1: layer++, go READ;
    - else at iteration end: if iter+1 == niter or iearly_stop==1 (sampled this cycle), go DONE; else iter++, layer=0, go READ.
  - DONE: odone=1 for one cycle, obusy=0 in the same cycle, go IDLE.
- Write path: D-deep shift register of {orread, oraddr, ortag}. owrite, owaddr and owtag equal the read values exactly D enabled cycles later.
- Layer period is pCOL_NUM + D + 1 cycles: reads, drain, transition cycle. No overlap between layers.
- oiter holds iter and updates on the READ entry of each new iteration. It holds its final value after odone until the next accepted istart.
- istart while busy: ignored. istart in the DONE cycle: ignored.
- Address arithmetic is unsigned and never wraps under the pADDR_W constraint.
- Out-of-range parameters are an elaboration error.

Test Plan:
- pROW_NUM=2, pCOL_NUM=4, D=10, initer=1:
  - reads at 0,1,2,3, then 4..7 starting 15 cycles after the first read;
  - writes to the same addresses exactly 10 cycles after each read;
  - odone one cycle after the DRAIN following the last write; obusy falls with odone.
- Same config, initer=3, iearly_stop=0:
  - 6 layers issued; oiter steps 0,1,2;
  - total decode is 6*15 cycles plus the start and done cycles.
- initer=5, iearly_stop asserted during the first iteration's final DRAIN: odone after iteration 0; oiter=0.
- Toggle iclkena low for 3 cycles mid-READ: address sequence is unchanged; read-to-write spacing is still 10 enabled cycles.
- Assert ireset=0 mid-DRAIN: all outputs are 0 next cycle and no odone; a following istart restarts from address 0.
- initer=0, and istart pulsed while busy: initer=0 runs exactly one iteration; istart while busy has no effect on the sequence.
